wb_skid_buffer: RTL and testbench
=================================

Name: wb_skid_buffer

Overview:
- Parametrised write-back stage buffer between the MEM stage and the register file. It is the successor to the single-register MEM/WB latch.
- Adds a valid/ready handshake, a 2-entry skid buffer so the upstream ready is registered, a synchronous flush, x0 write suppression and an occupancy output.
- The register file, or the arbiter in front of it, drives out_ready_i. The MEM stage sees in_ready_o as its stall.

Parameters:
DATA_W, 32, width of write-back data
ADDR_W, 5, width of destination register address
NOP_ADDR, 0, address driven on waddr_o when no valid entry is presented
ZERO_SUPPRESS, 1, when 1 a captured write whose waddr_i equals 0 is stored with wreg forced to 0

Ports:
rst  input  1  asynchronous reset, active-high
dclk  input  1  clock; all state updates on the rising edge
flush_i  input  1  synchronous flush; discards all held entries
in_valid_i  input  1  MEM stage presents a result
in_ready_o  output  1  buffer can accept a result this cycle
wreg_i  input  1  result writes the register file
waddr_i  input  ADDR_W  destination register
wdata_i  input  DATA_W  write-back data
out_valid_o  output  1  head entry valid
out_ready_i  input  1  register file accepts the head entry this cycle
wreg_o  output  1  head write enable, already qualified by out_valid_o
waddr_o  output  ADDR_W  head destination
wdata_o  output  DATA_W  head data
count_o  output  2  occupancy, 0..2

Behaviour:
- Reset is asynchronous on posedge rst:
  - state EMPTY; count_o=0; out_valid_o=0
  - wreg_o=0; waddr_o=NOP_ADDR; wdata_o=0
  - in_ready_o=1; skid entry cleared
- Storage is a head register (drives the outputs) plus a skid register.
- Handshakes:
  - push = in_valid_i & in_ready_o
  - pop = out_valid_o & out_ready_i
- in_ready_o = (state != FULL). It is a pure function of registered state and never depends combinationally on out_ready_i.
- Capture rule: stored wreg = wreg_i & ~(ZERO_SUPPRESS & (waddr_i == 0)). waddr and wdata are stored unchanged.
- FSM transitions (when flush_i=0):
  - EMPTY: push -> ONE, head loaded, latency 1 cycle input to output. No push -> EMPTY.
  - ONE, push & pop -> ONE, head replaced by the input (back-to-back streaming at 1 entry/cycle).
  - ONE, push & ~pop -> FULL, skid loaded, head held.
  - ONE, ~push & pop -> EMPTY, head cleared to the reset values.
  - ONE, neither -> ONE, head held.
  - FULL: pop -> ONE, head loaded from skid, skid cleared. No pop -> FULL, all held. Push cannot occur because in_ready_o=0.
- Ordering: entries leave in arrival order. No entry is lost or duplicated.
- Outputs whenever out_valid_o=0: wreg_o=0, waddr_o=NOP_ADDR, wdata_o=0.
- count_o: EMPTY=0, ONE=1, FULL=2.
- flush_i:
  - On the next edge, the state goes to EMPTY and all entries are cleared to the reset values.
  - flush_i has priority over push and pop in the same cycle, and the input offered that cycle is dropped.
  - A pop coinciding with flush is still seen by the consumer that cycle, since the outputs were valid before the edge. Flush does not retract it.
- Reset asserted mid-operation clears immediately and asynchronously, regardless of dclk. The first push after deassertion behaves as from EMPTY.
- out_ready_i while out_valid_o=0 is ignored.

Test Plan:
- Reset/idle: assert rst mid-stream with count_o=2 -> outputs immediately wreg_o=0, waddr_o=NOP_ADDR, wdata_o=0, count_o=0, in_ready_o=1.
- Streaming: out_ready_i=1, push (1,5,0x11), (1,6,0x22), (1,7,0x33) on consecutive cycles -> same triples on outputs one cycle later each, count_o=1 throughout, in_ready_o=1.
- Backpressure/skid:
  - out_ready_i=0, push A=(1,3,0xAA) then B=(1,4,0xBB) -> count_o=2, in_ready_o=0.
  - A third in_valid_i is not accepted.
  - Raise out_ready_i -> A, then B, then out_valid_o=0, count_o back to 0.
- x0 suppression: push (1,0,0xDEAD) -> out_valid_o=1, wreg_o=0, waddr_o=0, wdata_o=0xDEAD. With ZERO_SUPPRESS=0 -> wreg_o=1.
- Flush priority: state FULL, assert flush_i together with in_valid_i=1 (1,9,0x99) and out_ready_i=1 -> next cycle count_o=0, out_valid_o=0, and entry 0x99 never appears.
- Simultaneous push/pop in ONE: head=(1,2,0x1), push (1,8,0x8) with out_ready_i=1 -> next cycle head=(1,8,0x8), count_o=1, no skid use.

Source files
------------

// File: rtl/wb_skid_buffer.sv
// Write-back stage buffer between MEM and the register file: a two-entry skid
// buffer with a valid/ready handshake, synchronous flush and x0 write suppression.
module wb_skid_buffer #(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned ADDR_W        = 5,
  parameter int unsigned NOP_ADDR      = 0,
  parameter int unsigned ZERO_SUPPRESS = 1
) (
  input  logic              rst,
  input  logic              dclk,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              wreg_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              wreg_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [1:0]        count_o
);

  localparam logic [ADDR_W-1:0] NopAddr = ADDR_W'(NOP_ADDR);
  localparam logic              ZeroSup = (ZERO_SUPPRESS != 0);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e              state_q;
  logic                head_wreg_q, skid_wreg_q;
  logic [ADDR_W-1:0]   head_addr_q, skid_addr_q;
  logic [DATA_W-1:0]   head_data_q, skid_data_q;

  logic push, pop, cap_wreg;

  // in_ready depends only on registered state, never on out_ready_i.
  assign in_ready_o  = (state_q != StFull);
  assign out_valid_o = (state_q != StEmpty);
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;
  assign cap_wreg    = wreg_i & ~(ZeroSup & (waddr_i == '0));

  // Head registers are cleared whenever the buffer empties, so they can drive
  // the outputs directly.
  assign wreg_o  = head_wreg_q & out_valid_o;
  assign waddr_o = head_addr_q;
  assign wdata_o = head_data_q;

  always_comb begin
    count_o = 2'd0;
    unique case (state_q)
      StEmpty: count_o = 2'd0;
      StOne:   count_o = 2'd1;
      StFull:  count_o = 2'd2;
      default: count_o = 2'd0;
    endcase
  end

  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      state_q     <= StEmpty;
      head_wreg_q <= 1'b0;
      head_addr_q <= NopAddr;
      head_data_q <= '0;
      skid_wreg_q <= 1'b0;
      skid_addr_q <= NopAddr;
      skid_data_q <= '0;
    end else if (flush_i) begin
      state_q     <= StEmpty;
      head_wreg_q <= 1'b0;
      head_addr_q <= NopAddr;
      head_data_q <= '0;
      skid_wreg_q <= 1'b0;
      skid_addr_q <= NopAddr;
      skid_data_q <= '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (push) begin
            state_q     <= StOne;
            head_wreg_q <= cap_wreg;
            head_addr_q <= waddr_i;
            head_data_q <= wdata_i;
          end
        end
        StOne: begin
          if (push && pop) begin
            head_wreg_q <= cap_wreg;
            head_addr_q <= waddr_i;
            head_data_q <= wdata_i;
          end else if (push) begin
            state_q     <= StFull;
            skid_wreg_q <= cap_wreg;
            skid_addr_q <= waddr_i;
            skid_data_q <= wdata_i;
          end else if (pop) begin
            state_q     <= StEmpty;
            head_wreg_q <= 1'b0;
            head_addr_q <= NopAddr;
            head_data_q <= '0;
          end
        end
        StFull: begin
          if (pop) begin
            state_q     <= StOne;
            head_wreg_q <= skid_wreg_q;
            head_addr_q <= skid_addr_q;
            head_data_q <= skid_data_q;
            skid_wreg_q <= 1'b0;
            skid_addr_q <= NopAddr;
            skid_data_q <= '0;
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_skid_buffer.sv
// Directed bench for wb_skid_buffer; a second instance covers ZERO_SUPPRESS=0
// and a non-zero NOP_ADDR.
module tb_wb_skid_buffer;

  logic        rst, dclk, flush_i, in_valid_i, out_ready_i, wreg_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic        in_ready_o, out_valid_o, wreg_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;
  logic [1:0]  count_o;
  logic        b_in_ready, b_out_valid, b_wreg;
  logic [4:0]  b_waddr;
  logic [31:0] b_wdata;
  logic [1:0]  b_count;

  int n_chk = 0;
  int n_bad = 0;

  wb_skid_buffer dut (
    .rst(rst), .dclk(dclk), .flush_i(flush_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .wreg_i(wreg_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .wreg_o(wreg_o),
    .waddr_o(waddr_o), .wdata_o(wdata_o), .count_o(count_o)
  );

  wb_skid_buffer #(.NOP_ADDR(31), .ZERO_SUPPRESS(0)) dut_b (
    .rst(rst), .dclk(dclk), .flush_i(flush_i), .in_valid_i(in_valid_i),
    .in_ready_o(b_in_ready), .wreg_i(wreg_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .out_valid_o(b_out_valid), .out_ready_i(out_ready_i), .wreg_o(b_wreg),
    .waddr_o(b_waddr), .wdata_o(b_wdata), .count_o(b_count)
  );

  initial dclk = 1'b0;
  always #5 dclk = ~dclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge dclk);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [4:0] a, input logic [31:0] d);
    in_valid_i = v;
    wreg_i     = w;
    waddr_i    = a;
    wdata_i    = d;
  endtask

  task automatic head(input string tag, input logic v, input logic w, input logic [4:0] a,
                      input logic [31:0] d, input logic [1:0] c);
    check({tag, ".valid"}, {31'd0, out_valid_o}, {31'd0, v});
    check({tag, ".wreg"},  {31'd0, wreg_o}, {31'd0, w});
    check({tag, ".waddr"}, {27'd0, waddr_o}, {27'd0, a});
    check({tag, ".wdata"}, wdata_o, d);
    check({tag, ".count"}, {30'd0, count_o}, {30'd0, c});
    check({tag, ".ready"}, {31'd0, in_ready_o}, {31'd0, (c != 2'd2)});
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; out_ready_i = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    step(); step();
    head("reset", 1'b0, 1'b0, 5'd0, 32'd0, 2'd0);
    check("reset.b_waddr", {27'd0, b_waddr}, 32'd31);
    rst = 1'b0;

    // Streaming, one entry per cycle
    out_ready_i = 1'b1;
    drive(1'b1, 1'b1, 5'd5, 32'h11); step(); head("s1", 1'b1, 1'b1, 5'd5, 32'h11, 2'd1);
    drive(1'b1, 1'b1, 5'd6, 32'h22); step(); head("s2", 1'b1, 1'b1, 5'd6, 32'h22, 2'd1);
    drive(1'b1, 1'b1, 5'd7, 32'h33); step(); head("s3", 1'b1, 1'b1, 5'd7, 32'h33, 2'd1);
    drive(1'b0, 1'b0, 5'd0, 32'd0);  step(); head("s_end", 1'b0, 1'b0, 5'd0, 32'd0, 2'd0);

    // Backpressure: fill skid, refuse a third, drain in order
    out_ready_i = 1'b0;
    drive(1'b1, 1'b1, 5'd3, 32'hAA); step(); head("bp_a", 1'b1, 1'b1, 5'd3, 32'hAA, 2'd1);
    drive(1'b1, 1'b1, 5'd4, 32'hBB); step(); head("bp_full", 1'b1, 1'b1, 5'd3, 32'hAA, 2'd2);
    drive(1'b1, 1'b1, 5'd1, 32'hCC); step(); head("bp_third", 1'b1, 1'b1, 5'd3, 32'hAA, 2'd2);
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    out_ready_i = 1'b1;
    step(); head("bp_b", 1'b1, 1'b1, 5'd4, 32'hBB, 2'd1);
    step(); head("bp_empty", 1'b0, 1'b0, 5'd0, 32'd0, 2'd0);

    // x0 suppression
    out_ready_i = 1'b0;
    drive(1'b1, 1'b1, 5'd0, 32'hDEAD); step();
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    head("x0", 1'b1, 1'b0, 5'd0, 32'hDEAD, 2'd1);
    check("x0.b_wreg", {31'd0, b_wreg}, 32'd1);
    out_ready_i = 1'b1; step(); head("x0_empty", 1'b0, 1'b0, 5'd0, 32'd0, 2'd0);
    check("x0.b_nop", {27'd0, b_waddr}, 32'd31);

    // Simultaneous push and pop in ONE
    drive(1'b1, 1'b1, 5'd2, 32'h1); step(); head("pp1", 1'b1, 1'b1, 5'd2, 32'h1, 2'd1);
    drive(1'b1, 1'b1, 5'd8, 32'h8); step(); head("pp2", 1'b1, 1'b1, 5'd8, 32'h8, 2'd1);
    drive(1'b0, 1'b0, 5'd0, 32'd0); step(); head("pp_end", 1'b0, 1'b0, 5'd0, 32'd0, 2'd0);

    // Flush beats push and pop in the same cycle
    out_ready_i = 1'b0;
    drive(1'b1, 1'b1, 5'd3, 32'hAA); step();
    drive(1'b1, 1'b1, 5'd4, 32'hBB); step();
    drive(1'b1, 1'b1, 5'd9, 32'h99);
    flush_i = 1'b1; out_ready_i = 1'b1;
    head("fl_pre", 1'b1, 1'b1, 5'd3, 32'hAA, 2'd2);
    step();
    flush_i = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    head("fl_post", 1'b0, 1'b0, 5'd0, 32'd0, 2'd0);
    step(); head("fl_no99", 1'b0, 1'b0, 5'd0, 32'd0, 2'd0);

    // Asynchronous reset mid-cycle with count=2
    out_ready_i = 1'b0;
    drive(1'b1, 1'b1, 5'd3, 32'hAA); step();
    drive(1'b1, 1'b1, 5'd4, 32'hBB); step();
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    check("ar_pre.count", {30'd0, count_o}, 32'd2);
    #2 rst = 1'b1;
    #1 head("ar", 1'b0, 1'b0, 5'd0, 32'd0, 2'd0);
    check("ar.b_waddr", {27'd0, b_waddr}, 32'd31);
    #1 rst = 1'b0;
    drive(1'b1, 1'b1, 5'd5, 32'h55); step(); head("ar_push", 1'b1, 1'b1, 5'd5, 32'h55, 2'd1);
    drive(1'b0, 1'b0, 5'd0, 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
